apb_mem_slave: RTL and testbench
================================

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 64, meaning number of DATA_WIDTH words.
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning byte address of word 0.
REQ-005 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states per transfer (0..15).
REQ-006 SHALL have port PCLK, input, 1, meaning the single clock for all state.
REQ-007 SHALL have port PRESETn, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port PSEL, input, 1, meaning slave select (one bit of the master's PSELx).
REQ-009 SHALL have ports PADDR (input, ADDR_WIDTH), PENABLE (input, 1), PWRITE (input, 1) and PWDATA (input, DATA_WIDTH), meaning the APB3 request.
REQ-010 SHALL have ports PREADY (output, 1), PRDATA (output, DATA_WIDTH) and PSLVERR (output, 1), meaning the APB3 response.
REQ-011 SHALL have port protocol_error, output, 1, meaning a one-cycle pulse on each detected APB protocol violation.

Function
REQ-012 SHALL implement an FSM with states IDLE and ACCESS.
REQ-013 SHALL, in IDLE, on a setup phase (PSEL=1, PENABLE=0), latch PADDR, PWRITE and PWDATA and go to ACCESS.
REQ-014 SHALL treat an address as valid only if PADDR[1:0]==0 and BASE_ADDR <= PADDR < BASE_ADDR+4*MEM_DEPTH, with word index (PADDR-BASE_ADDR)>>2.
REQ-015 SHALL load a wait counter with WAIT_CYCLES at the setup edge, and decrement it once per ACCESS cycle while it is nonzero.
REQ-016 SHALL drive PREADY as a register: set at the setup edge when WAIT_CYCLES==0, otherwise set at the edge where the counter goes 1->0, so exactly WAIT_CYCLES PREADY=0 access cycles precede completion.
REQ-017 SHALL complete a transfer at the edge where PSEL, PENABLE and PREADY are all 1, then clear PREADY, PSLVERR and PRDATA and return to IDLE.
REQ-018 SHALL, for a valid write, commit the latched PWDATA to memory at the completion edge only.
REQ-019 SHALL, for a valid read, load PRDATA from memory on the same edge PREADY is set; PRDATA SHALL be 0 at all other times.
REQ-020 SHALL, for an invalid address, assert PSLVERR together with PREADY, hold PRDATA=0, and leave memory unchanged.
REQ-021 SHALL accept back-to-back transfers: a setup phase in the cycle after completion SHALL be taken with no idle cycle inserted.
REQ-022 SHALL ignore PADDR, PWRITE and PWDATA changes during ACCESS, using the latched values.
REQ-023 SHALL pulse protocol_error and stay in IDLE, with no response, on PSEL=1 and PENABLE=1 in IDLE.
REQ-024 SHALL pulse protocol_error, abort without a memory write, clear PREADY and return to IDLE on PSEL=0 or PENABLE=0 in ACCESS before completion.

Reset
REQ-025 SHALL, while PRESETn=0, immediately force state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, protocol_error=0 and wait counter 0.
REQ-026 SHALL NOT reset memory contents, and SHALL NOT commit an in-flight write when reset is asserted mid-transfer.

Structure
REQ-027 SHALL take the FSM state enum and the APB phase constants from the shared package apb_pkg.
REQ-028 SHALL instantiate the storage as sub-module mem_sp_ram, a single-port RAM with synchronous write, combinational read, MEM_DEPTH x DATA_WIDTH and no reset.

Verification (WAIT_CYCLES=2, MEM_DEPTH=64, BASE_ADDR=0)
REQ-029 SHALL check: write 0xDEADBEEF to 0x10, then read 0x10 -> PREADY=1 in the third access cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-030 SHALL check: read 0x100, then write 0x102 -> PSLVERR=1 with PREADY on both transfers, PRDATA=0, memory unchanged.
REQ-031 SHALL check: back-to-back writes to 0x04 and 0x08 with no idle cycle -> both accepted, 8 cycles total, both readback values correct.
REQ-032 SHALL check: PSEL=1, PENABLE=1 applied in IDLE -> protocol_error=1 for one cycle, PREADY stays 0.
REQ-033 SHALL check: PSEL dropped in wait cycle 1 of a write of 0x5A5A5A5A to 0x20 -> protocol_error pulse, and readback of 0x20 returns the old value.
REQ-034 SHALL check: PRESETn=0 mid-wait of a write -> PREADY, PSLVERR and PRDATA are 0 before the next edge, state IDLE, write not committed.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared APB definitions: FSM state encoding and the {PSEL, PENABLE}
//   phase codes used to classify each bus cycle.
package apb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_t;

   // Phase codes are {PSEL, PENABLE}
   localparam logic [1:0] PH_IDLE   = 2'b00;
   localparam logic [1:0] PH_SETUP  = 2'b10;
   localparam logic [1:0] PH_ACCESS = 2'b11;

endpackage

// File: rtl/mem_sp_ram.sv
// mem_sp_ram
//   Single-port RAM, DEPTH x WIDTH, synchronous write, combinational read.
//   Contents are deliberately not reset.
// Ports:
//   clk   - write clock
//   we    - write enable, sampled on the rising edge of clk
//   addr  - word address, shared by read and write
//   wdata - write data
//   rdata - read data, combinational from addr
module mem_sp_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 32,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave
//   APB3 slave backed by a MEM_DEPTH-word RAM, with a fixed number of wait
//   states per transfer and a protocol-violation pulse output.
// Ports:
//   PCLK, PRESETn              - clock, async active-low reset
//   PSEL, PENABLE, PWRITE      - APB3 control
//   PADDR, PWDATA              - APB3 request address / write data
//   PREADY, PRDATA, PSLVERR    - APB3 response (all registered)
//   protocol_error             - one-cycle pulse per detected violation
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no transfer in flight; waiting for a setup phase
// ST_ACCESS | request latched; counting wait states, then completing
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    MEM_DEPTH   = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_CYCLES = 2
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PREADY,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PSLVERR,
   output logic                  protocol_error
);

   localparam int                  IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] ADDR_LO   = {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0] ADDR_SPAN = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
   localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);

   apb_state_t state, state_next;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            wait_cnt;

   logic [1:0]            phase;
   logic                  do_setup, do_complete, do_abort, err_next, set_ready;

   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_write;
   logic [ADDR_WIDTH:0]   addr_off;
   logic                  addr_ok;
   logic [IDX_W-1:0]      ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  ram_we;

   assign phase = {PSEL, PENABLE};

   // In IDLE the response may be produced at the setup edge (zero wait
   // states), so decode the live bus; otherwise use the latched request.
   assign sel_addr  = (state == ST_IDLE) ? PADDR  : addr_q;
   assign sel_write = (state == ST_IDLE) ? PWRITE : write_q;

   // One extra bit catches addresses below BASE_ADDR as a borrow.
   assign addr_off = {1'b0, sel_addr} - ADDR_LO;
   assign addr_ok  = (sel_addr[1:0] == 2'b00) && !addr_off[ADDR_WIDTH] &&
                     (addr_off < ADDR_SPAN);
   assign ram_addr = IDX_W'(addr_off >> 2);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      do_setup    = 1'b0;
      do_complete = 1'b0;
      do_abort    = 1'b0;
      err_next    = 1'b0;
      set_ready   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (phase == PH_SETUP) begin
               do_setup   = 1'b1;
               set_ready  = (WAIT_CYCLES == 0);
               state_next = ST_ACCESS;
            end else if (phase == PH_ACCESS) begin
               err_next = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (phase != PH_ACCESS) begin
               do_abort   = 1'b1;
               err_next   = 1'b1;
               state_next = ST_IDLE;
            end else if (PREADY) begin
               do_complete = 1'b1;
               state_next  = ST_IDLE;
            end else begin
               set_ready = (wait_cnt == 4'd1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Memory is only ever written at the completion edge of a valid write.
   assign ram_we = do_complete && write_q && addr_ok;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         addr_q         <= '0;
         write_q        <= 1'b0;
         wdata_q        <= '0;
         wait_cnt       <= '0;
         PREADY         <= 1'b0;
         PSLVERR        <= 1'b0;
         PRDATA         <= '0;
         protocol_error <= 1'b0;
      end else begin
         protocol_error <= err_next;

         if (do_setup) begin
            addr_q   <= PADDR;
            write_q  <= PWRITE;
            wdata_q  <= PWDATA;
            wait_cnt <= WAIT_INIT;
         end else if (do_abort) begin
            wait_cnt <= '0;
         end else if (state == ST_ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if (do_complete || do_abort) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
         end else if (set_ready) begin
            PREADY  <= 1'b1;
            PSLVERR <= !addr_ok;
            PRDATA  <= (addr_ok && !sel_write) ? ram_rdata : '0;
         end
      end
   end

   mem_sp_ram #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (DATA_WIDTH),
      .AW    (IDX_W)
   ) u_ram (
      .clk   (PCLK),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;
   import apb_pkg::*;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA;
   logic        PREADY, PSLVERR, protocol_error;
   logic [31:0] PRDATA;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   apb_mem_slave #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .MEM_DEPTH   (64),
      .BASE_ADDR   (32'h0),
      .WAIT_CYCLES (2)
   ) dut (
      .PCLK           (PCLK),
      .PRESETn        (PRESETn),
      .PSEL           (PSEL),
      .PADDR          (PADDR),
      .PENABLE        (PENABLE),
      .PWRITE         (PWRITE),
      .PWDATA         (PWDATA),
      .PREADY         (PREADY),
      .PRDATA         (PRDATA),
      .PSLVERR        (PSLVERR),
      .protocol_error (protocol_error)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Called #1 after an edge; drives setup now and returns in the cycle
   // where PREADY is seen high (or after a bounded number of cycles).
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input string nm);
      int n;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      n = 0;
      do begin
         @(posedge PCLK); #1;
         PENABLE = 1'b1;
         // request lines are garbage during access; the slave must use its latch
         PADDR = ~addr; PWDATA = ~wdata; PWRITE = ~wr;
         n++;
         if (!PREADY) chk({nm, " prdata_wait"}, PRDATA, 32'd0);
      end while (!PREADY && n < 10);
      chk({nm, " ready_cycle"}, 32'(n), 32'd3);
      chk({nm, " prdata"}, PRDATA, exp_rdata);
      chk({nm, " pslverr"}, 32'(PSLVERR), 32'(exp_err));
      chk({nm, " perr"}, 32'(protocol_error), 32'd0);
   endtask

   // Lets the completion edge pass and checks that the response cleared.
   task automatic finish_xfer(input string nm);
      @(posedge PCLK); #1;
      chk({nm, " ready_clr"}, 32'(PREADY), 32'd0);
      chk({nm, " prdata_clr"}, PRDATA, 32'd0);
      chk({nm, " slverr_clr"}, 32'(PSLVERR), 32'd0);
   endtask

   task automatic go_idle();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      @(posedge PCLK); #1;
   endtask

   initial begin
      int c0;

      vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b0, 32'h100, 32'h0,        32'h0,        1'b1};
      vecs[3]  = '{1'b1, 32'h102, 32'h12345678, 32'h0,        1'b1};
      vecs[4]  = '{1'b1, 32'h12,  32'h11111111, 32'h0,        1'b1};
      vecs[5]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[6]  = '{1'b1, 32'hFC,  32'hA5A5F00F, 32'h0,        1'b0};
      vecs[7]  = '{1'b0, 32'hFC,  32'h0,        32'hA5A5F00F, 1'b0};
      vecs[8]  = '{1'b1, 32'h20,  32'h11223344, 32'h0,        1'b0};
      vecs[9]  = '{1'b1, 32'h30,  32'h33333333, 32'h0,        1'b0};
      vecs[10] = '{1'b1, 32'h00,  32'h0BADCAFE, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 32'h00,  32'h0,        32'h0BADCAFE, 1'b0};

      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0;
      #23;
      chk("rst pready", 32'(PREADY), 32'd0);
      chk("rst pslverr", 32'(PSLVERR), 32'd0);
      chk("rst prdata", PRDATA, 32'd0);
      chk("rst perr", 32'(protocol_error), 32'd0);
      chk("rst state", 32'(dut.state), 32'(ST_IDLE));
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      go_idle();

      for (int i = 0; i < 12; i++) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
              $sformatf("vec%0d", i));
         finish_xfer($sformatf("vec%0d", i));
         go_idle();
      end

      // back-to-back writes, no idle cycle between
      c0 = cyc;
      xfer(1'b1, 32'h04, 32'h04040404, 32'h0, 1'b0, "b2b_w1");
      @(posedge PCLK); #1;
      xfer(1'b1, 32'h08, 32'h08080808, 32'h0, 1'b0, "b2b_w2");
      chk("b2b cycles", 32'(cyc - c0 + 1), 32'd8);
      finish_xfer("b2b_w2");
      go_idle();
      xfer(1'b0, 32'h04, 32'h0, 32'h04040404, 1'b0, "b2b_r1");
      finish_xfer("b2b_r1");
      go_idle();
      xfer(1'b0, 32'h08, 32'h0, 32'h08080808, 1'b0, "b2b_r2");
      finish_xfer("b2b_r2");
      go_idle();

      // access phase seen while idle
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h10;
      @(posedge PCLK); #1;
      chk("idle_acc perr", 32'(protocol_error), 32'd1);
      chk("idle_acc pready", 32'(PREADY), 32'd0);
      chk("idle_acc state", 32'(dut.state), 32'(ST_IDLE));
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      chk("idle_acc perr_end", 32'(protocol_error), 32'd0);
      chk("idle_acc pready2", 32'(PREADY), 32'd0);

      // PSEL dropped in wait cycle 1 of a write
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h20; PWDATA = 32'h5A5A5A5A;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b1;
      @(posedge PCLK); #1;
      chk("abort perr", 32'(protocol_error), 32'd1);
      chk("abort pready", 32'(PREADY), 32'd0);
      chk("abort state", 32'(dut.state), 32'(ST_IDLE));
      PENABLE = 1'b0; PWRITE = 1'b0;
      @(posedge PCLK); #1;
      chk("abort perr_end", 32'(protocol_error), 32'd0);
      xfer(1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, "abort_rd");
      finish_xfer("abort_rd");
      go_idle();

      // reset mid-wait of a write
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'hCAFEF00D;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      #1;
      chk("rstw pready", 32'(PREADY), 32'd0);
      chk("rstw pslverr", 32'(PSLVERR), 32'd0);
      chk("rstw prdata", PRDATA, 32'd0);
      chk("rstw state", 32'(dut.state), 32'(ST_IDLE));
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      go_idle();
      xfer(1'b0, 32'h30, 32'h0, 32'h33333333, 1'b0, "rstw_rd");
      finish_xfer("rstw_rd");
      go_idle();

      // reset while a read response is being presented
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h10;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      chk("rstr pre_ready", 32'(PREADY), 32'd1);
      chk("rstr pre_prdata", PRDATA, 32'hDEADBEEF);
      PRESETn = 1'b0;
      #1;
      chk("rstr pready", 32'(PREADY), 32'd0);
      chk("rstr prdata", PRDATA, 32'd0);
      chk("rstr state", 32'(dut.state), 32'(ST_IDLE));
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      go_idle();
      xfer(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "post_rst_rd");
      finish_xfer("post_rst_rd");
      go_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
